// File: rtl/dac_out_ctrl.sv
// DDS-to-DAC0832 output stage: scales a sample about mid-scale, adds an offset and drives the DAC bus/strobes.
// Define DAC_SAT_EN to clamp the result to the DAC range; otherwise the result wraps modulo 2**DW.
module dac_out_ctrl #(
  parameter int DW     = 8,
  parameter int AMP_W  = 8,
  parameter int OFF_W  = 9,
  parameter int MODE   = 0,
  parameter int WR_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    s_data,
  input  logic [AMP_W-1:0] s_amp,
  input  logic [OFF_W-1:0] s_off,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [DW-1:0]    dac_data,
  output logic [4:0]       dac_ctrl,
  output logic             dac_done,
  output logic [2:0]       dbg_state
);

  localparam int PW = DW + AMP_W + 2;
  localparam int RW = PW + 1;
  localparam int MID = 2 ** (DW - 1);
  localparam logic [DW:0] MID_X = (DW + 1)'(MID);
  localparam int CW = (WR_CYC > 1) ? $clog2(WR_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(WR_CYC - 1);
  localparam logic [4:0] CTRL_RST = (MODE == 0) ? 5'b10000 : 5'b11111;

  typedef enum logic [2:0] {IDLE, SETUP, WR, HOLD, XFER} state_t;

  // Handshake: a sample moves into P1 on any rising edge where s_valid && s_ready.
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    p1_valid_q, p1_valid_d;
  logic                    p2_valid_q, p2_valid_d;
  logic signed [PW-1:0]    p_q, p_d;
  logic signed [OFF_W-1:0] off_q;
  logic [DW-1:0]           dac_data_q, dac_data_d, res;
  logic [4:0]              ctrl_q, ctrl_d;
  logic                    done_q, done_d;
  logic signed [DW:0]      c;
  logic                    accept, last;

  function automatic logic [4:0] ctrl_of(input state_t s);
    case (s)
      SETUP, HOLD: ctrl_of = 5'b10111;
      WR:          ctrl_of = 5'b10011;
      XFER:        ctrl_of = 5'b11100;
      default:     ctrl_of = 5'b11111;
    endcase
  endfunction

  assign s_ready   = (MODE == 0) ? 1'b1 : (state_q == IDLE && !p1_valid_q && !p2_valid_q);
  assign accept    = s_valid && s_ready;
  assign last      = (cnt_q == LAST);
  assign c         = $signed({1'b0, s_data} - MID_X);
  assign p_d       = PW'(c) * PW'($signed({1'b0, s_amp}));
  assign dac_data  = dac_data_q;
  assign dac_ctrl  = ctrl_q;
  assign dac_done  = done_q;
  assign dbg_state = state_q;

  // P2 arithmetic: widths are large enough that only the final DW-bit reduction loses information.
  always_comb begin
    res = '0;
`ifdef DAC_SAT_EN
    begin
      logic signed [RW-1:0] r;
      r = RW'(MID) + RW'(p_q >>> (AMP_W - 1)) + RW'(off_q);
      if (r[RW-1])             res = '0;
      else if (|r[RW-2:DW])    res = '1;
      else                     res = r[DW-1:0];
    end
`else
    res = DW'(RW'(MID) + RW'(p_q >>> (AMP_W - 1)) + RW'(off_q));
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p1_valid_d = accept;
    dac_data_d = p1_valid_q ? res : dac_data_q;
    case (state_q)
      IDLE:  if (MODE != 0 && p1_valid_q) state_d = SETUP;
      SETUP: begin state_d = WR; cnt_d = '0; end
      WR:    if (last) begin state_d = HOLD; cnt_d = '0; end
             else cnt_d = cnt_q + 1'b1;
      HOLD:  begin state_d = XFER; cnt_d = '0; end
      XFER:  if (last) begin state_d = IDLE; cnt_d = '0; end
             else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
    // In strobed mode P2 stays occupied until the transfer strobe completes.
    if (MODE == 0) begin
      p2_valid_d = p1_valid_q;
      done_d     = p2_valid_q;
      ctrl_d     = 5'b10000;
    end else begin
      p2_valid_d = p1_valid_q || (p2_valid_q && !(state_q == XFER && last));
      done_d     = (state_q == XFER) && last;
      ctrl_d     = ctrl_of(state_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      p1_valid_q <= 1'b0;
      p2_valid_q <= 1'b0;
      p_q        <= '0;
      off_q      <= '0;
      dac_data_q <= DW'(MID);
      ctrl_q     <= CTRL_RST;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p1_valid_q <= p1_valid_d;
      p2_valid_q <= p2_valid_d;
      if (accept) begin
        p_q   <= p_d;
        off_q <= $signed(s_off);
      end
      dac_data_q <= dac_data_d;
      ctrl_q     <= ctrl_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_dac_out_ctrl.sv
// Bench for dac_out_ctrl: one transparent-mode and one strobed-mode instance on a shared clock/reset.
module tb_dac_out_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] m0_data = '0, m0_amp = '0, m1_data = '0, m1_amp = '0;
  logic [8:0] m0_off = '0, m1_off = '0;
  logic m0_valid = 1'b0, m1_valid = 1'b0;
  logic m0_ready, m1_ready, m0_done, m1_done;
  logic [7:0] m0_dac, m1_dac;
  logic [4:0] m0_ctrl, m1_ctrl;
  logic [2:0] m0_dbg, m1_dbg;

  dac_out_ctrl #(.MODE(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .s_data(m0_data), .s_amp(m0_amp), .s_off(m0_off),
    .s_valid(m0_valid), .s_ready(m0_ready), .dac_data(m0_dac), .dac_ctrl(m0_ctrl),
    .dac_done(m0_done), .dbg_state(m0_dbg)
  );

  dac_out_ctrl #(.MODE(1), .WR_CYC(2)) u_m1 (
    .clk(clk), .rst_n(rst_n), .s_data(m1_data), .s_amp(m1_amp), .s_off(m1_off),
    .s_valid(m1_valid), .s_ready(m1_ready), .dac_data(m1_dac), .dac_ctrl(m1_ctrl),
    .dac_done(m1_done), .dbg_state(m1_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: integer arithmetic with floor division standing in for the arithmetic shift.
  function automatic logic [7:0] model(input int d, input int a, input int o);
    int p, q, r;
    p = (d - 128) * a;
    if (p >= 0) q = p / 128;
    else        q = -((-p + 127) / 128);
    r = 128 + q + o;
`ifdef DAC_SAT_EN
    if (r < 0) r = 0;
    else if (r > 255) r = 255;
`else
    r = ((r % 256) + 256) % 256;
`endif
    return 8'(r);
  endfunction

  typedef struct {
    logic [7:0]        d;
    logic [7:0]        a;
    logic signed [8:0] o;
    logic [7:0]        e_wrap;
    logic [7:0]        e_sat;
  } vec_t;

  typedef struct {
    logic              v;
    logic [7:0]        d;
    logic [7:0]        a;
    logic signed [8:0] o;
    logic [7:0]        e;
  } stim_t;

  vec_t  tbl[12];
  stim_t stim[$];
  logic [7:0] exp_q[$];

  initial begin
    logic [7:0] last_exp;
    logic [4:0] seq[8];
    int t;
    stim_t s;

    tbl[0]  = '{8'hC0, 8'd128,  9'sd0,   8'hC0, 8'hC0};
    tbl[1]  = '{8'hC0, 8'd64,   9'sd0,   8'hA0, 8'hA0};
    tbl[2]  = '{8'h00, 8'd128,  9'sd0,   8'h00, 8'h00};
    tbl[3]  = '{8'hFF, 8'd128,  9'sd0,   8'hFF, 8'hFF};
    tbl[4]  = '{8'hFF, 8'd255,  9'sd0,   8'h7D, 8'hFF};
    tbl[5]  = '{8'h10, 8'd128, -9'sd32,  8'hF0, 8'h00};
    tbl[6]  = '{8'h80, 8'd200,  9'sd5,   8'h85, 8'h85};
    tbl[7]  = '{8'h00, 8'd255,  9'sd0,   8'h81, 8'h00};
    tbl[8]  = '{8'h40, 8'd0,    9'sd0,   8'h80, 8'h80};
    tbl[9]  = '{8'h7F, 8'd128,  9'sd255, 8'h7E, 8'hFF};
    tbl[10] = '{8'h01, 8'd1,   -9'sd256, 8'h7F, 8'h00};
    tbl[11] = '{8'hFF, 8'd129,  9'sd0,   8'hFF, 8'hFF};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_m0_ctrl", 32'(m0_ctrl), 32'h10);
    check("rst_m1_ctrl", 32'(m1_ctrl), 32'h1F);
    check("rst_m0_data", 32'(m0_dac), 32'h80);
    check("rst_m1_data", 32'(m1_dac), 32'h80);
    check("rst_m0_done", 32'(m0_done), 32'h0);
    check("rst_m1_done", 32'(m1_done), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_m1_ready", 32'(m1_ready), 32'h1);

    // MODE 0 stream: table vectors back to back, then random traffic with bubbles
    foreach (tbl[i]) begin
      s.v = 1'b1; s.d = tbl[i].d; s.a = tbl[i].a; s.o = tbl[i].o;
`ifdef DAC_SAT_EN
      s.e = tbl[i].e_sat;
`else
      s.e = tbl[i].e_wrap;
`endif
      stim.push_back(s);
    end
    for (int i = 0; i < 200; i++) begin
      s.v = ($urandom_range(0, 3) != 0);
      s.d = 8'($urandom_range(0, 255));
      s.a = 8'($urandom_range(0, 255));
      s.o = 9'($urandom_range(0, 511));
      s.e = model(int'(s.d), int'(s.a), int'(s.o));
      stim.push_back(s);
    end
    last_exp = 8'h80;
    for (int j = 0; j < stim.size() + 4; j++) begin
      if (j >= 2 && stim[j-2].v) last_exp = exp_q.pop_front();
      check("m0_data", 32'(m0_dac), 32'(last_exp));
      check("m0_done", 32'(m0_done), 32'(j >= 3 && stim[j-3].v));
      check("m0_ready", 32'(m0_ready), 32'h1);
      check("m0_ctrl", 32'(m0_ctrl), 32'h10);
      if (j < stim.size()) begin
        m0_valid = stim[j].v; m0_data = stim[j].d; m0_amp = stim[j].a; m0_off = stim[j].o;
        if (stim[j].v) exp_q.push_back(stim[j].e);
      end else begin
        m0_valid = 1'b0;
      end
      @(negedge clk);
    end

    // MODE 1 strobe sequence with a second sample held off until ready
    seq = '{5'b11111, 5'b10111, 5'b10011, 5'b10011, 5'b10111, 5'b11100, 5'b11100, 5'b11111};
    m1_valid = 1'b1; m1_data = 8'hFF; m1_amp = 8'd128; m1_off = 9'd0;
    check("t5_ready0", 32'(m1_ready), 32'h1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) m1_data = 8'h40;
      check("t5_ctrl", 32'(m1_ctrl), 32'(seq[k-1]));
      check("t5_done", 32'(m1_done), 32'(k == 8));
      check("t5_ready", 32'(m1_ready), 32'(k == 8));
      if (k >= 2) check("t5_data", 32'(m1_dac), 32'hFF);
    end
    @(negedge clk);
    m1_valid = 1'b0;
    check("t5_ctrl2_p1", 32'(m1_ctrl), 32'h1F);
    check("t5_ready2", 32'(m1_ready), 32'h0);
    @(negedge clk);
    check("t5_ctrl2_setup", 32'(m1_ctrl), 32'h17);
    check("t5_data2", 32'(m1_dac), 32'h40);
    t = 0;
    while (!m1_done && t < 20) begin @(negedge clk); t++; end
    check("t5_done2_timeout", 32'(t < 20), 32'h1);

    // MODE 1 randomized samples against the model
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      m1_valid = 1'b1;
      m1_data = 8'($urandom_range(0, 255));
      m1_amp  = 8'($urandom_range(0, 255));
      m1_off  = 9'($urandom_range(0, 511));
      t = 0;
      while (!m1_ready && t < 20) begin @(negedge clk); t++; end
      check("m1_accept_timeout", 32'(t < 20), 32'h1);
      exp_q.push_back(model(int'(m1_data), int'(m1_amp), int'($signed(m1_off))));
      @(negedge clk);
      m1_valid = 1'b0;
      t = 0;
      while (!m1_done && t < 20) begin @(negedge clk); t++; end
      check("m1_done_timeout", 32'(t < 20), 32'h1);
      check("m1_rand_data", 32'(m1_dac), 32'(exp_q.pop_front()));
    end

    // Reset in the middle of the WR phase
    @(negedge clk);
    m1_valid = 1'b1; m1_data = 8'h20; m1_amp = 8'd128; m1_off = 9'd0;
    t = 0;
    while (!m1_ready && t < 20) begin @(negedge clk); t++; end
    check("t6_accept_timeout", 32'(t < 20), 32'h1);
    repeat (3) @(negedge clk);
    m1_valid = 1'b0;
    check("t6_in_wr", 32'(m1_ctrl), 32'h13);
    check("t6_data_before", 32'(m1_dac), 32'h20);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_ctrl", 32'(m1_ctrl), 32'h1F);
    check("t6_data", 32'(m1_dac), 32'h80);
    check("t6_done", 32'(m1_done), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_ready", 32'(m1_ready), 32'h1);
    repeat (12) @(negedge clk);
    check("t6_ctrl_idle", 32'(m1_ctrl), 32'h1F);
    check("t6_no_done", 32'(m1_done), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
